// File: rtl/gl_operand_capture_if.sv
// gl_operand_capture_if: UART rx/tx, result and operand bundle
// for gl_operand_capture.
interface gl_operand_capture_if #(
    parameter int WIDTH = 8
);
    logic [7:0]       rx_data;
    logic             rx_data_rdy;
    logic             tx_busy;
    logic [7:0]       res_data;
    logic             res_rdy;
    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] r2;
    logic             subtract;
    logic             adder_start;
    logic [7:0]       tx_data;
    logic             tx_data_rdy;
    logic             soft_rst;
    logic             echo_ovf;

    modport master (
        output rx_data, rx_data_rdy, tx_busy, res_data, res_rdy,
        input  r1, r2, subtract, adder_start,
        input  tx_data, tx_data_rdy, soft_rst, echo_ovf
    );

    modport slave (
        input  rx_data, rx_data_rdy, tx_busy, res_data, res_rdy,
        output r1, r2, subtract, adder_start,
        output tx_data, tx_data_rdy, soft_rst, echo_ovf
    );
endinterface

// File: rtl/gl_operand_capture.sv
// gl_operand_capture: hex operand / operator capture with UART echo FIFO.
// Optional: define UPPER_HEX_EN to also accept 'A'-'F' as hex digits.
module gl_operand_capture #(
    parameter int WIDTH       = 8,
    parameter int ECHO_DEPTH  = 4,
    parameter int SRST_CYCLES = 16
) (
    input logic clk,
    input logic resetq,
    gl_operand_capture_if.slave bus
);
    localparam int ND = WIDTH / 4;
    localparam int CW = (ND > 1) ? $clog2(ND) : 1;
    localparam int AW = (ECHO_DEPTH > 1) ? $clog2(ECHO_DEPTH) : 1;
    localparam int SW = $clog2(SRST_CYCLES + 1);
    localparam logic [CW-1:0] LAST      = CW'(ND - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [SW-1:0] SRST_LOAD = SW'(SRST_CYCLES);
    localparam logic [SW-1:0] SRST_ONE  = SW'(1);
    localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

    typedef enum logic [1:0] {GET1, GET2, GETOP, START} state_t;

    state_t state_q, state_n;

    logic [WIDTH-1:0] r1_q, r2_q;
    logic             sub_q, start_q;
    logic [CW-1:0]    cnt_q;
    logic [SW-1:0]    srst_q;
    logic             soft_rst;
    logic [7:0]       ech_d;
    logic             ech_v;
    logic [7:0]       mem [ECHO_DEPTH];
    logic [AW:0]      wr_q, rd_q;
    logic [7:0]       tx_q;
    logic             txr_q;
    logic             ovf_q;

    logic       is_dig, is_op, is_esc, rx_ok, esc;
    logic [3:0] nib;
    logic       take_dig, take_op, take;
    logic       push, pop, full, empty, wr_en, ovf_set;
    logic       ech_take, ech_drop;
    logic [7:0] push_d;

    function automatic logic [WIDTH-1:0] shift_in(
        input logic [WIDTH-1:0] acc,
        input logic             first,
        input logic [3:0]       n
    );
        logic [WIDTH-1:0] base;
        logic [WIDTH+3:0] t;
        base = first ? '0 : acc;
        t = {base, n};
        return t[WIDTH-1:0];
    endfunction

    // Hex digit decode of the received byte.
    always_comb begin
        is_dig = 1'b0;
        nib    = 4'h0;
        if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) begin
            is_dig = 1'b1;
            nib    = bus.rx_data[3:0];
        end else if (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66) begin
            is_dig = 1'b1;
            nib    = bus.rx_data[3:0] + 4'd9;
        end
`ifdef UPPER_HEX_EN
        else if (bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46) begin
            is_dig = 1'b1;
            nib    = bus.rx_data[3:0] + 4'd9;
        end
`endif
    end

    assign is_op    = (bus.rx_data == 8'h2B) || (bus.rx_data == 8'h2D);
    assign is_esc   = (bus.rx_data == 8'h1B);
    assign soft_rst = (srst_q != '0);
    assign rx_ok    = bus.rx_data_rdy && !soft_rst;
    assign esc      = bus.rx_data_rdy && is_esc;
    assign take     = take_dig || take_op;

    // Next state and character acceptance.
    always_comb begin
        state_n  = state_q;
        take_dig = 1'b0;
        take_op  = 1'b0;
        unique case (state_q)
            GET1: begin
                if (rx_ok && is_dig) begin
                    take_dig = 1'b1;
                    if (cnt_q == LAST) state_n = GET2;
                end
            end
            GET2: begin
                if (rx_ok && is_dig) begin
                    take_dig = 1'b1;
                    if (cnt_q == LAST) state_n = GETOP;
                end
            end
            GETOP: begin
                if (rx_ok && is_op) begin
                    take_op = 1'b1;
                    state_n = START;
                end
            end
            START:   state_n = GET1;
            default: state_n = GET1;
        endcase
        if (esc) state_n = GET1;
    end

    // State register.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) state_q <= GET1;
        else         state_q <= state_n;
    end

    // Operands, operator, digit counter and start pulse.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r1_q    <= '0;
            r2_q    <= '0;
            sub_q   <= 1'b0;
            cnt_q   <= '0;
            start_q <= 1'b0;
        end else begin
            start_q <= (state_q == START) && !esc;
            if (esc) begin
                r1_q  <= '0;
                r2_q  <= '0;
                sub_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                if (take_dig) begin
                    if (state_q == GET1)
                        r1_q <= shift_in(r1_q, cnt_q == '0, nib);
                    else
                        r2_q <= shift_in(r2_q, cnt_q == '0, nib);
                    cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_ONE;
                end
                if (take_op) sub_q <= (bus.rx_data == 8'h2D);
                if (state_q == START) cnt_q <= '0;
            end
        end
    end

    // Soft reset window, restarted by every ESC.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq)       srst_q <= '0;
        else if (esc)      srst_q <= SRST_LOAD;
        else if (soft_rst) srst_q <= srst_q - SRST_ONE;
    end

    // Result bytes win the push slot; the echo byte waits in ech_d.
    always_comb begin
        push     = bus.res_rdy || ech_v;
        push_d   = bus.res_rdy ? bus.res_data : ech_d;
        ech_take = ech_v && !bus.res_rdy;
        ech_drop = take && ech_v && !ech_take;
        empty    = (wr_q == rd_q);
        full     = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop      = !empty && !bus.tx_busy && !txr_q;
        wr_en    = push && (!full || pop);
        ovf_set  = (push && full && !pop) || ech_drop;
    end

    // Echo hold register for accepted characters.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            ech_v <= 1'b0;
            ech_d <= '0;
        end else if (take) begin
            ech_v <= 1'b1;
            ech_d <= bus.rx_data;
        end else if (ech_take) begin
            ech_v <= 1'b0;
        end
    end

    // Echo FIFO storage and pointers.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < ECHO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_q[AW-1:0]] <= push_d;
                wr_q <= wr_q + PTR_ONE;
            end
            if (pop) rd_q <= rd_q + PTR_ONE;
        end
    end

    // Transmit strobe with a guaranteed idle cycle between bytes.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_q  <= '0;
            txr_q <= 1'b0;
        end else begin
            txr_q <= pop;
            if (pop) tx_q <= mem[rd_q[AW-1:0]];
        end
    end

    // Sticky overflow flag, cleared only by ESC.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq)      ovf_q <= 1'b0;
        else if (esc)     ovf_q <= 1'b0;
        else if (ovf_set) ovf_q <= 1'b1;
    end

    assign bus.r1          = r1_q;
    assign bus.r2          = r2_q;
    assign bus.subtract    = sub_q;
    assign bus.adder_start = start_q;
    assign bus.tx_data     = tx_q;
    assign bus.tx_data_rdy = txr_q;
    assign bus.soft_rst    = soft_rst;
    assign bus.echo_ovf    = ovf_q;
endmodule

// File: tb/tb_gl_operand_capture.sv
// tb_gl_operand_capture: directed vectors for gl_operand_capture,
// one WIDTH=8/depth 4 and one WIDTH=16/depth 2 instance on shared rx.
module tb_gl_operand_capture;
    logic       clk = 1'b0;
    logic       resetq = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_data_rdy = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] res_data = '0;
    logic       res_rdy = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int na_start = 0;
    int nb_start = 0;
    int nb_srst = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int qbc[$];

    gl_operand_capture_if #(.WIDTH(8))  ia();
    gl_operand_capture_if #(.WIDTH(16)) ib();

    assign ia.rx_data     = rx_data;
    assign ia.rx_data_rdy = rx_data_rdy;
    assign ia.tx_busy     = tx_busy;
    assign ia.res_data    = res_data;
    assign ia.res_rdy     = res_rdy;
    assign ib.rx_data     = rx_data;
    assign ib.rx_data_rdy = rx_data_rdy;
    assign ib.tx_busy     = tx_busy;
    assign ib.res_data    = res_data;
    assign ib.res_rdy     = res_rdy;

    gl_operand_capture #(.WIDTH(8), .ECHO_DEPTH(4), .SRST_CYCLES(16)) ua (
        .clk(clk), .resetq(resetq), .bus(ia)
    );
    gl_operand_capture #(.WIDTH(16), .ECHO_DEPTH(2), .SRST_CYCLES(16)) ub (
        .clk(clk), .resetq(resetq), .bus(ib)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (ia.tx_data_rdy) qa.push_back(ia.tx_data);
        if (ib.tx_data_rdy) begin
            qb.push_back(ib.tx_data);
            qbc.push_back(cyc);
        end
        if (ia.adder_start) na_start++;
        if (ib.adder_start) nb_start++;
        if (ib.soft_rst) nb_srst++;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_seq(string tag, input logic [7:0] q[$], input string s);
        check({tag, "_len"}, q.size(), s.len());
        for (int i = 0; i < s.len(); i++)
            check(tag, (i < q.size()) ? q[i] : 8'h00, s[i]);
    endtask

    task automatic drive(logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_data_rdy = 1'b1;
        @(negedge clk);
        rx_data_rdy = 1'b0;
    endtask

    task automatic send(logic [7:0] b);
        drive(b);
        repeat (4) @(negedge clk);
    endtask

    task automatic send_str(string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    initial begin
        string exp_a;
        repeat (3) @(negedge clk);
        resetq = 1'b1;
        @(negedge clk);

        check("rst_r1", ia.r1, 0);
        check("rst_r2", ib.r2, 0);
        check("rst_sub", ia.subtract, 0);
        check("rst_start", ib.adder_start, 0);
        check("rst_txr", ia.tx_data_rdy, 0);
        check("rst_tx", ib.tx_data, 0);
        check("rst_srst", ia.soft_rst, 0);
        check("rst_ovf", ib.echo_ovf, 0);

        send_str("3a05");
        check("a_r1", ia.r1, 8'h3A);
        check("a_r2", ia.r2, 8'h05);
        drive("+");
        check("a_start_c1", ia.adder_start, 0);
        @(negedge clk);
        check("a_start_c2", ia.adder_start, 1);
        @(negedge clk);
        check("a_start_c3", ia.adder_start, 0);
        repeat (10) @(negedge clk);
        check("a_npulse", na_start, 1);
        check("a_sub", ia.subtract, 0);
        chk_seq("a_tx", qa, "3a05+");

        qa.delete();
        send("7");
        check("a_fresh", ia.r1, 8'h07);
        send("1");
        check("a_r1b", ia.r1, 8'h71);
        send_str("00-");
        repeat (4) @(negedge clk);
        check("a_r2b", ia.r2, 8'h00);
        check("a_subb", ia.subtract, 1);
        check("a_npulse2", na_start, 2);

        send_str("ABcd+");
        repeat (4) @(negedge clk);
`ifdef UPPER_HEX_EN
        check("up_r1", ia.r1, 8'hAB);
        check("up_r2", ia.r2, 8'hCD);
        check("up_sub", ia.subtract, 0);
        check("up_npulse", na_start, 3);
        send("a");
        check("up_lower", ia.r1, 8'h0A);
        exp_a = "7100-ABcd+a";
`else
        check("up_r1", ia.r1, 8'hCD);
        check("up_r2", ia.r2, 8'h00);
        check("up_npulse", na_start, 2);
        send("a");
        check("up_lower", ia.r2, 8'h0A);
        exp_a = "7100-cda";
`endif
        repeat (10) @(negedge clk);
        chk_seq("a_tx2", qa, exp_a);

        @(negedge clk);
        resetq = 1'b0;
        repeat (2) @(negedge clk);
        resetq = 1'b1;
        qb.delete();
        qbc.delete();
        nb_start = 0;
        @(negedge clk);

        send_str("ffff00z+01");
        check("b_r1", ib.r1, 16'hFFFF);
        check("b_r2", ib.r2, 16'h0001);
        send("-");
        repeat (6) @(negedge clk);
        check("b_sub", ib.subtract, 1);
        check("b_npulse", nb_start, 1);
        check("b_ovf0", ib.echo_ovf, 0);
        chk_seq("b_tx", qb, "ffff0001-");

        qb.delete();
        send_str("12");
        check("b_fresh", ib.r1, 16'h0012);
        nb_srst = 0;
        drive(8'h1B);
        check("esc_srst", ib.soft_rst, 1);
        check("esc_r1", ib.r1, 0);
        check("esc_r2", ib.r2, 0);
        check("esc_sub", ib.subtract, 0);
        send("9");
        repeat (20) @(negedge clk);
        check("esc_len", nb_srst, 16);
        check("esc_srst_end", ib.soft_rst, 0);
        check("esc_ign", ib.r1, 0);
        send_str("1234");
        check("esc_reload", ib.r1, 16'h1234);
        repeat (6) @(negedge clk);
        chk_seq("esc_tx", qb, "121234");

        qb.delete();
        qbc.delete();
        tx_busy = 1'b1;
        send_str("abc");
        check("ovf_set", ib.echo_ovf, 1);
        check("ovf_held", qb.size(), 0);
        tx_busy = 1'b0;
        repeat (15) @(negedge clk);
        chk_seq("ovf_tx", qb, "ab");
        check("ovf_gap", (qbc.size() == 2) && (qbc[1] - qbc[0] >= 2), 1);
        check("ovf_sticky", ib.echo_ovf, 1);
        send(8'h1B);
        check("ovf_clr", ib.echo_ovf, 0);
        repeat (20) @(negedge clk);

        qb.delete();
        @(negedge clk);
        rx_data = "5";
        rx_data_rdy = 1'b1;
        @(negedge clk);
        rx_data_rdy = 1'b0;
        res_data = 8'h99;
        res_rdy = 1'b1;
        @(negedge clk);
        res_rdy = 1'b0;
        repeat (10) @(negedge clk);
        check("res_len", qb.size(), 2);
        check("res_first", (qb.size() > 0) ? qb[0] : 8'h00, 8'h99);
        check("res_echo", (qb.size() > 1) ? qb[1] : 8'h00, 8'h35);
        check("res_r1", ib.r1, 16'h0005);

        send("6");
        repeat (6) @(negedge clk);
        check("pre_tx", ib.tx_data, 8'h36);
        check("pre_r1", ib.r1, 16'h0056);
        drive(8'h1B);
        check("pre_srst", ib.soft_rst, 1);
        #2 resetq = 1'b0;
        #1;
        check("ar_r1", ib.r1, 0);
        check("ar_r2", ib.r2, 0);
        check("ar_sub", ib.subtract, 0);
        check("ar_start", ib.adder_start, 0);
        check("ar_tx", ib.tx_data, 0);
        check("ar_txr", ib.tx_data_rdy, 0);
        check("ar_srst", ib.soft_rst, 0);
        check("ar_ovf", ib.echo_ovf, 0);
        check("ar_a_tx", ia.tx_data, 0);
        check("ar_a_r1", ia.r1, 0);
        @(negedge clk);
        resetq = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
